pipelined_adder_nbit: RTL and testbench

// - Parametrised, pipelined successor to the fixed 22-bit ripple adder in the TPU accumulate path.
// - Splits a WIDTH-bit add/sub into SEGS ripple segments, one segment per pipeline stage, with the carry registered between stages.
// - Adds a valid/ready handshake, a subtract mode, carry-out and signed-overflow flags.
// - Sits between the MAC array partial-sum outputs and the accumulator SRAM write port.

---
 rtl/pipelined_adder_nbit.sv | 134 +++++++++++++
 tb/tb_pipelined_adder_nbit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/sub split into SEGS ripple segments, one segment per stage, with
// valid/ready flow control. Define ADDER_SAT_EN to saturate signed overflow in the last stage.
module pipelined_adder_nbit #(
   parameter int unsigned WIDTH = 22,
   parameter int unsigned SEGS  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned SW = WIDTH / SEGS;
   localparam int unsigned NP = (SEGS > 1) ? SEGS - 1 : 1;
   localparam int unsigned L  = SEGS - 1;

   if (WIDTH % SEGS != 0) begin : g_param_check
      $error("pipelined_adder_nbit: WIDTH must be a multiple of SEGS");
   end

   logic             adv;

   // Inter-stage registers: operand skew, partial result and segment carry
   logic             v_q [NP];
   logic [WIDTH-1:0] a_q [NP];
   logic [WIDTH-1:0] b_q [NP];
   logic [WIDTH-1:0] s_q [NP];
   logic             c_q [NP];

   logic             v_in [SEGS];
   logic [WIDTH-1:0] a_in [SEGS];
   logic [WIDTH-1:0] b_in [SEGS];
   logic [WIDTH-1:0] s_in [SEGS];
   logic             c_in [SEGS];
   logic [WIDTH-1:0] s_d  [SEGS];
   logic             c_d  [SEGS];

   logic             c_msb;
   logic             ovf_d;
   logic [WIDTH-1:0] res_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             ovf_q;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Stage 0 takes the port operands; B is inverted and carry-in set for subtract
   assign v_in[0] = in_valid;
   assign a_in[0] = input1;
   assign b_in[0] = input2 ^ {WIDTH{sub}};
   assign c_in[0] = sub;
   assign s_in[0] = '0;

   for (genvar k = 1; k < SEGS; k++) begin : g_link
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
   end

   for (genvar k = 0; k < SEGS; k++) begin : g_stage
      localparam int unsigned LO = k * SW;
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << LO;

      logic [SW:0] seg;

      assign seg    = {1'b0, a_in[k][LO +: SW]} + {1'b0, b_in[k][LO +: SW]}
                    + (SW+1)'(c_in[k]);
      assign s_d[k] = (s_in[k] & ~MASK) | (WIDTH'(seg[SW-1:0]) << LO);
      assign c_d[k] = seg[SW];
   end

   // Carry into the MSB recovered from the MSB sum bit and its two operand bits
   assign c_msb = s_d[L][WIDTH-1] ^ a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1];
   assign ovf_d = c_msb ^ c_d[L];

`ifdef ADDER_SAT_EN
   // Overflow only happens when both addends share a sign, so A's MSB gives the direction
   always_comb begin
      res_d = s_d[L];
      if (ovf_d) begin
         res_d = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign res_d = s_d[L];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(NP); k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (adv) begin
         for (int k = 0; k < int'(SEGS) - 1; k++) begin
            v_q[k] <= v_in[k];
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
         end
         out_valid_q <= v_in[L];
         result_q    <= res_d;
         carry_q     <= c_d[L];
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Bench for pipelined_adder_nbit: directed vector table on SEGS=2 and SEGS=11 instances,
// randomized stream with stalls against an arithmetic reference model, and reset mid-flight.
module tb_pipelined_adder_nbit;

   localparam int unsigned W = 22;

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         sub;
   logic         out_ready;
   logic [W-1:0] input1;
   logic [W-1:0] input2;
   logic         in_ready;
   logic         out_valid;
   logic         carry_out;
   logic         overflow;
   logic [W-1:0] result;
   logic         in_ready11;
   logic         out_valid11;
   logic         carry_out11;
   logic         overflow11;
   logic [W-1:0] result11;

   int   checks   = 0;
   int   failures = 0;
   int   drained  = 0;
   exp_t exp_q[$];
   logic hold_pending = 1'b0;
   exp_t held;
   vec_t tbl[8];

   always #5 clk = ~clk;

   pipelined_adder_nbit #(.WIDTH(W), .SEGS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .input1    (input1),
      .input2    (input2),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   pipelined_adder_nbit #(.WIDTH(W), .SEGS(11)) dut11 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready11),
      .input1    (input1),
      .input2    (input2),
      .sub       (sub),
      .out_valid (out_valid11),
      .out_ready (out_ready),
      .result    (result11),
      .carry_out (carry_out11),
      .overflow  (overflow11)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations of the operands
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t        e;
      longint      ua, ub, sa, sb, full, sr, smax, smin;
      logic [63:0] fb;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      if (!s) begin
         full = ua + ub;
         e.co = (full >= (longint'(1) << W));
         sr   = sa + sb;
      end else begin
         full = ua - ub;
         e.co = (ua >= ub);
         sr   = sa - sb;
      end
      fb    = full;
      e.res = fb[W-1:0];
      e.ov  = (sr > smax) || (sr < smin);
`ifdef ADDER_SAT_EN
      if (e.ov) e.res = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
      return e;
   endfunction

   // One beat into an empty pipe; measures latency on both instances
   task automatic send_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                              output int lat2, output int lat11, output logic [W-1:0] r2,
                              output logic co2, output logic ov2, output logic [W-1:0] r11);
      lat2  = -1;
      lat11 = -1;
      r2    = '0;
      co2   = 1'b0;
      ov2   = 1'b0;
      r11   = '0;
      @(negedge clk);
      in_valid  = 1'b1;
      input1    = a;
      input2    = b;
      sub       = s;
      out_ready = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (lat2 < 0 && out_valid) begin
            lat2 = n;
            r2   = result;
            co2  = carry_out;
            ov2  = overflow;
         end
         if (lat11 < 0 && out_valid11) begin
            lat11 = n;
            r11   = result11;
         end
         if (lat2 >= 0 && lat11 >= 0) break;
      end
   endtask

   // One cycle of scoreboarded traffic on the SEGS=2 instance
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic rdy, output logic acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      input1    = a;
      input2    = b;
      sub       = s;
      out_ready = rdy;
      #1;
      if (hold_pending) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(held.res));
         check("hold_flags", {30'd0, carry_out, overflow}, {30'd0, held.co, held.ov});
      end
      check("in_ready_rule", 32'(in_ready), 32'(!out_valid || rdy));
      acc = v && in_ready;
      if (out_valid && rdy) begin
         drained++;
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat_result", 32'(result), 32'(e.res));
            check("beat_flags", {30'd0, carry_out, overflow}, {30'd0, e.co, e.ov});
         end
      end
      if (acc) exp_q.push_back(model(a, b, s));
      hold_pending = out_valid && !rdy;
      held         = '{res: result, co: carry_out, ov: overflow};
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           lat2, lat11, sent, d0, stale;
      logic [W-1:0] r2, r11;
      logic         co2, ov2, acc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      input1    = '0;
      input2    = '0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags", {30'd0, carry_out, overflow}, 32'd0);
      check("reset_out_valid11", 32'(out_valid11), 32'd0);

      tbl[0] = '{22'h3FFFFF, 22'h000001, 1'b0, 22'h000000, 1'b1, 1'b0};
      tbl[1] = '{22'h000005, 22'h000007, 1'b1, 22'h3FFFFE, 1'b0, 1'b0};
`ifdef ADDER_SAT_EN
      tbl[2] = '{22'h1FFFFF, 22'h000001, 1'b0, 22'h1FFFFF, 1'b0, 1'b1};
      tbl[4] = '{22'h200000, 22'h000001, 1'b1, 22'h200000, 1'b1, 1'b1};
      tbl[7] = '{22'h200000, 22'h200000, 1'b0, 22'h200000, 1'b1, 1'b1};
`else
      tbl[2] = '{22'h1FFFFF, 22'h000001, 1'b0, 22'h200000, 1'b0, 1'b1};
      tbl[4] = '{22'h200000, 22'h000001, 1'b1, 22'h1FFFFF, 1'b1, 1'b1};
      tbl[7] = '{22'h200000, 22'h200000, 1'b0, 22'h000000, 1'b1, 1'b1};
`endif
      tbl[3] = '{22'h0007FF, 22'h000001, 1'b0, 22'h000800, 1'b0, 1'b0};
      tbl[5] = '{22'h123456, 22'h123456, 1'b1, 22'h000000, 1'b1, 1'b0};
      tbl[6] = '{22'h2AAAAA, 22'h155555, 1'b0, 22'h3FFFFF, 1'b0, 1'b0};

      for (int i = 0; i < 8; i++) begin
         send_single(tbl[i].a, tbl[i].b, tbl[i].s, lat2, lat11, r2, co2, ov2, r11);
         check($sformatf("vec%0d_result", i), 32'(r2), 32'(tbl[i].res));
         check($sformatf("vec%0d_carry", i), 32'(co2), 32'(tbl[i].co));
         check($sformatf("vec%0d_overflow", i), 32'(ov2), 32'(tbl[i].ov));
         check($sformatf("vec%0d_latency", i), 32'(lat2), 32'd2);
         check($sformatf("vec%0d_result_s11", i), 32'(r11), 32'(tbl[i].res));
         check($sformatf("vec%0d_latency_s11", i), 32'(lat11), 32'd11);
      end
      repeat (3) @(negedge clk);

      // Eight back-to-back beats with the sink stalled for cycles 4-6
      sent = 0;
      d0   = drained;
      for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
         step(sent < 8, 22'(sent), 22'h000100, 1'b0, !(c >= 4 && c <= 6), acc);
         if (acc) sent++;
      end
      check("stream_sent", 32'(sent), 32'd8);
      check("stream_drained", 32'(drained - d0), 32'd8);
      check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

      for (int c = 0; c < 400; c++) begin
         logic [W-1:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? 22'h1FFFFF : 22'($urandom);
         b = ($urandom_range(0, 3) == 0) ? 22'h200000 : 22'($urandom);
         step($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 7, acc);
      end
      for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1, acc);
      end
      check("random_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with two beats in flight, first with the sink ready, then mid-stall
      for (int r = 0; r < 2; r++) begin
         repeat (15) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
         step(1'b1, 22'h000011, 22'h000022, 1'b0, r == 0, acc);
         step(1'b1, 22'h000033, 22'h000044, 1'b0, r == 0, acc);
         @(negedge clk);
         in_valid = 1'b0;
         rst      = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         #1;
         check($sformatf("rst%0d_out_valid", r), 32'(out_valid), 32'd0);
         check($sformatf("rst%0d_in_ready", r), 32'(in_ready), 32'd1);
         check($sformatf("rst%0d_result", r), 32'(result), 32'd0);
         check($sformatf("rst%0d_out_valid11", r), 32'(out_valid11), 32'd0);
         exp_q.delete();
         hold_pending = 1'b0;
         out_ready    = 1'b1;
         stale        = 0;
         for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            #1;
            if (out_valid || out_valid11) stale++;
         end
         check($sformatf("rst%0d_no_stale", r), 32'(stale), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
